// File: rtl/rsa_job_arbiter.sv
//------------------------------------------------------------------------------
// rsa_job_arbiter
//
// Shares one RSA256 exponentiation core between two requesters. Jobs (a, d, n)
// arrive on per-requester valid/ready ports and are granted round-robin. For
// each job the core is cleared with a one-cycle reset pulse, launched with a
// one-cycle start pulse and watched until it reports completion. The 256-bit
// result is then returned to the owning requester on a valid/ready port.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_req_valid[1:0]    job request per requester
//   o_req_ready[1:0]    job accept per requester (combinational, IDLE only)
//   i_req_a/d/n[511:0]  operands, requester k at [256k+255:256k]
//   o_rsp_valid[1:0]    result valid per requester (registered)
//   i_rsp_ready[1:0]    result accept per requester
//   o_rsp_data[255:0]   result, shared by both requesters
//   o_rsp_err           watchdog timeout flag, qualified by o_rsp_valid
//   o_core_rst_n        core reset, active-low (registered)
//   o_core_start        core start pulse (registered)
//   o_core_a/d/n        operands of the job in flight (registered)
//   i_core_result       core result
//   i_core_finished     core done level, sticky until the core is reset
//
// Build option
//   RSA_ARB_TIMEOUT_EN  when defined, a BUSY watchdog of TIMEOUT_CYCLES ends a
//                       job with o_rsp_err=1 and o_rsp_data=0.
//------------------------------------------------------------------------------
module rsa_job_arbiter #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [1:0]   i_req_valid,
    output logic [1:0]   o_req_ready,
    input  logic [511:0] i_req_a,
    input  logic [511:0] i_req_d,
    input  logic [511:0] i_req_n,
    output logic [1:0]   o_rsp_valid,
    input  logic [1:0]   i_rsp_ready,
    output logic [255:0] o_rsp_data,
    output logic         o_rsp_err,
    output logic         o_core_rst_n,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_START = 3'd2,
        S_BUSY  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t       state_q;
    logic         last_grant_q;
    logic         owner_q;
    logic         core_rst_n_q;
    logic         core_start_q;
    logic [255:0] core_a_q;
    logic [255:0] core_d_q;
    logic [255:0] core_n_q;
    logic [1:0]   rsp_valid_q;
    logic [255:0] rsp_data_q;

    logic         sel_valid_s;
    logic         sel_idx_s;
    logic [255:0] sel_a_s;
    logic [255:0] sel_d_s;
    logic [255:0] sel_n_s;
    logic         rsp_hs_s;

`ifdef RSA_ARB_TIMEOUT_EN
    logic         rsp_err_q;
    logic [31:0]  wd_cnt_q;
`else
    // Parameter is intentionally inert when the watchdog is not built.
    logic         unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    // Requester selection: a lone request wins, a tie goes to the one not served last
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = 1'b0;
        case (i_req_valid)
            2'b01: begin
                sel_valid_s = 1'b1;
                sel_idx_s   = 1'b0;
            end
            2'b10: begin
                sel_valid_s = 1'b1;
                sel_idx_s   = 1'b1;
            end
            2'b11: begin
                sel_valid_s = 1'b1;
                sel_idx_s   = ~last_grant_q;
            end
            default: begin
                sel_valid_s = 1'b0;
                sel_idx_s   = 1'b0;
            end
        endcase
    end

    // Operand mux for the selected requester
    always_comb begin
        if (sel_idx_s) begin
            sel_a_s = i_req_a[511:256];
            sel_d_s = i_req_d[511:256];
            sel_n_s = i_req_n[511:256];
        end else begin
            sel_a_s = i_req_a[255:0];
            sel_d_s = i_req_d[255:0];
            sel_n_s = i_req_n[255:0];
        end
    end

    // Accept only in IDLE and only on the selected bit
    always_comb begin
        o_req_ready = 2'b00;
        if ((state_q == S_IDLE) && sel_valid_s) begin
            o_req_ready = sel_idx_s ? 2'b10 : 2'b01;
        end else begin
            o_req_ready = 2'b00;
        end
    end

    // Only the owner's ready bit can complete a response
    assign rsp_hs_s = i_rsp_ready[owner_q];

    // Job sequencing FSM; all core controls and response outputs are registered here
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
            core_start_q <= 1'b0;
            core_a_q     <= 256'd0;
            core_d_q     <= 256'd0;
            core_n_q     <= 256'd0;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= 256'd0;
`ifdef RSA_ARB_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
            wd_cnt_q     <= 32'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    core_start_q <= 1'b0;
                    if (sel_valid_s) begin
                        // The selected requester is ready, so valid means handshake.
                        core_a_q     <= sel_a_s;
                        core_d_q     <= sel_d_s;
                        core_n_q     <= sel_n_s;
                        owner_q      <= sel_idx_s;
                        core_rst_n_q <= 1'b0;
                        state_q      <= S_CLR;
                    end else begin
                        // Also releases the core after arbiter reset on the first edge.
                        core_rst_n_q <= 1'b1;
                    end
                end
                S_CLR: begin
                    core_rst_n_q <= 1'b1;
                    core_start_q <= 1'b1;
                    state_q      <= S_START;
                end
                S_START: begin
                    core_start_q <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
                    wd_cnt_q     <= 32'd0;
`endif
                    state_q      <= S_BUSY;
                end
                S_BUSY: begin
                    if (i_core_finished) begin
                        rsp_data_q  <= i_core_result;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
`ifdef RSA_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= S_RESP;
                    end
`ifdef RSA_ARB_TIMEOUT_EN
                    // Core is left running; the next job's CLR pulse clears it.
                    else if ((wd_cnt_q + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
                        rsp_data_q  <= 256'd0;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wd_cnt_q    <= wd_cnt_q + 32'd1;
                    end
`else
                    else begin
                        state_q <= S_BUSY;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_q  <= 2'b00;
                        last_grant_q <= owner_q;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    core_rst_n_q <= 1'b1;
                    core_start_q <= 1'b0;
                    rsp_valid_q  <= 2'b00;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign o_core_rst_n = core_rst_n_q;
    assign o_core_start = core_start_q;
    assign o_core_a     = core_a_q;
    assign o_core_d     = core_d_q;
    assign o_core_n     = core_n_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_data   = rsp_data_q;
`ifdef RSA_ARB_TIMEOUT_EN
    assign o_rsp_err    = rsp_err_q;
`else
    assign o_rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_job_arbiter.sv
//------------------------------------------------------------------------------
// tb_rsa_job_arbiter
//
// Drives two requesters and a behavioural RSA core model. A cycle-level
// reference model, written from the arbiter's externally visible rules, predicts
// ready, core control pulses, operands and responses every cycle.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rsa_job_arbiter;

    localparam int TO_CYCLES = 100;

    logic         i_clk;
    logic         i_rst;
    logic [1:0]   i_req_valid;
    logic [1:0]   o_req_ready;
    logic [511:0] i_req_a;
    logic [511:0] i_req_d;
    logic [511:0] i_req_n;
    logic [1:0]   o_rsp_valid;
    logic [1:0]   i_rsp_ready;
    logic [255:0] o_rsp_data;
    logic         o_rsp_err;
    logic         o_core_rst_n;
    logic         o_core_start;
    logic [255:0] o_core_a;
    logic [255:0] o_core_d;
    logic [255:0] o_core_n;
    logic [255:0] i_core_result;
    logic         i_core_finished;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    rsa_job_arbiter #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_a        (i_req_a),
        .i_req_d        (i_req_d),
        .i_req_n        (i_req_n),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_data     (o_rsp_data),
        .o_rsp_err      (o_rsp_err),
        .o_core_rst_n   (o_core_rst_n),
        .o_core_start   (o_core_start),
        .o_core_a       (o_core_a),
        .o_core_d       (o_core_d),
        .o_core_n       (o_core_n),
        .i_core_result  (i_core_result),
        .i_core_finished(i_core_finished)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // a^d mod n by repeated multiplication; operands stay small in this bench
    function automatic logic [255:0] modexp(input logic [255:0] a, input logic [255:0] d,
                                            input logic [255:0] n);
        logic [511:0] r;
        logic [511:0] b;
        logic [511:0] nn;
        if (n == 256'd0 || d > 256'd64) return 256'hE;
        nn = {256'd0, n};
        b  = {256'd0, a} % nn;
        r  = 512'd1 % nn;
        for (int i = 0; i < int'(d[7:0]); i++) r = (r * b) % nn;
        return r[255:0];
    endfunction

    // ---------------- behavioural core ----------------
    logic         core_fin_r;
    logic         core_run_r;
    logic [255:0] core_res_r;
    int           core_cnt_r;
    logic         core_hang;

    always @(posedge i_clk) begin
        if (!o_core_rst_n) begin
            core_fin_r <= 1'b0;
            core_run_r <= 1'b0;
            core_cnt_r <= 0;
        end else if (o_core_start) begin
            core_fin_r <= 1'b0;
            core_run_r <= 1'b1;
            core_cnt_r <= int'($urandom_range(1, 12));
            core_res_r <= modexp(o_core_a, o_core_d, o_core_n);
        end else if (core_run_r && !core_hang) begin
            if (core_cnt_r <= 1) begin
                core_fin_r <= 1'b1;
                core_run_r <= 1'b0;
            end else begin
                core_cnt_r <= core_cnt_r - 1;
            end
        end
    end
    assign i_core_finished = core_fin_r;
    assign i_core_result   = core_fin_r ? core_res_r : ~core_res_r;

    // ---------------- reference model / monitor ----------------
    typedef struct packed { logic owner; logic err; logic [255:0] data; } rsp_t;
    rsp_t rsp_log[$];

    logic         m_busy, m_owner, m_rsp, m_err, m_last, m_rstn_ok;
    int           m_age, m_bcnt;
    logic [255:0] m_a, m_d, m_n, m_data;
    logic [1:0]   acc_hs;
    int           cyc = 0, start_cyc = 0, rspv_cyc = 0;
    logic         prev_rspv = 1'b0;

    always @(negedge i_clk) begin : mon
        logic [1:0] exp_rdy;
        logic [1:0] exp_rspv;
        cyc++;
        if (!i_rst) begin
            check_val("rst_rsp_valid", o_rsp_valid, 256'd0);
            check_val("rst_rsp_data", o_rsp_data, 256'd0);
            check_val("rst_rsp_err", o_rsp_err, 256'd0);
            check_val("rst_core_rst_n", o_core_rst_n, 256'd0);
            check_val("rst_core_start", o_core_start, 256'd0);
            check_val("rst_core_a", o_core_a, 256'd0);
            check_val("rst_core_d", o_core_d, 256'd0);
            check_val("rst_core_n", o_core_n, 256'd0);
            m_busy = 1'b0; m_rsp = 1'b0; m_err = 1'b0; m_last = 1'b1; m_owner = 1'b0;
            m_rstn_ok = 1'b0; m_age = 0; m_bcnt = 0;
            m_a = 256'd0; m_d = 256'd0; m_n = 256'd0; m_data = 256'd0;
            acc_hs = 2'b00; prev_rspv = 1'b0;
        end else begin
            exp_rdy = 2'b00;
            if (!m_busy) begin
                if (i_req_valid == 2'b01) exp_rdy = 2'b01;
                else if (i_req_valid == 2'b10) exp_rdy = 2'b10;
                else if (i_req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
            end
            exp_rspv = m_rsp ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            check_val("req_ready", o_req_ready, exp_rdy);
            check_val("core_rst_n", o_core_rst_n, m_rstn_ok && !(m_busy && m_age == 1));
            check_val("core_start", o_core_start, m_busy && m_age == 2);
            check_val("rsp_valid", o_rsp_valid, exp_rspv);
            if (m_rsp) begin
                check_val("rsp_data", o_rsp_data, m_data);
                check_val("rsp_err", o_rsp_err, m_err);
            end
            check_val("core_a", o_core_a, m_a);
            check_val("core_d", o_core_d, m_d);
            check_val("core_n", o_core_n, m_n);

            acc_hs = i_req_valid & o_req_ready;
            if (|(o_rsp_valid & i_rsp_ready))
                rsp_log.push_back('{owner: o_rsp_valid[1], err: o_rsp_err, data: o_rsp_data});
            if (o_core_start) start_cyc = cyc;
            if ((|o_rsp_valid) && !prev_rspv) rspv_cyc = cyc;
            prev_rspv = |o_rsp_valid;

            // advance the model across the coming clock edge
            if (|(exp_rdy & i_req_valid)) begin
                m_busy  = 1'b1;
                m_owner = exp_rdy[1];
                m_a = exp_rdy[1] ? i_req_a[511:256] : i_req_a[255:0];
                m_d = exp_rdy[1] ? i_req_d[511:256] : i_req_d[255:0];
                m_n = exp_rdy[1] ? i_req_n[511:256] : i_req_n[255:0];
                m_age = 1; m_rsp = 1'b0; m_bcnt = 0;
            end else if (m_busy) begin
                if (m_rsp) begin
                    if (i_rsp_ready[m_owner]) begin
                        m_busy = 1'b0; m_rsp = 1'b0; m_last = m_owner;
                    end
                end else begin
                    if (m_age >= 3) begin
                        if (i_core_finished) begin
                            m_rsp = 1'b1; m_err = 1'b0; m_data = modexp(m_a, m_d, m_n);
                        end
`ifdef RSA_ARB_TIMEOUT_EN
                        else begin
                            m_bcnt++;
                            if (m_bcnt >= TO_CYCLES) begin
                                m_rsp = 1'b1; m_err = 1'b1; m_data = 256'd0;
                            end
                        end
`endif
                    end
                    m_age++;
                end
            end
            m_rstn_ok = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct packed { logic [255:0] a; logic [255:0] d; logic [255:0] n; } job_t;
    job_t jobq0[$];
    job_t jobq1[$];
    int   rsp_mode;   // 0 random, 1 always ready, 2 never ready
    bit   wd_en;      // random withdrawal of valid before acceptance

    function automatic job_t mk(input int a, input int d, input int n);
        job_t j;
        j.a = 256'(a); j.d = 256'(d); j.n = 256'(n);
        return j;
    endfunction

    task automatic drive();
        if (acc_hs[0] && jobq0.size() > 0) void'(jobq0.pop_front());
        if (acc_hs[1] && jobq1.size() > 0) void'(jobq1.pop_front());
        if (jobq0.size() > 0) begin
            i_req_valid[0]   = wd_en ? ($urandom_range(0, 5) != 0) : 1'b1;
            i_req_a[255:0]   = jobq0[0].a;
            i_req_d[255:0]   = jobq0[0].d;
            i_req_n[255:0]   = jobq0[0].n;
        end else begin
            i_req_valid[0]   = 1'b0;
            i_req_a[255:0]   = {8{$urandom()}};
            i_req_d[255:0]   = {8{$urandom()}};
            i_req_n[255:0]   = {8{$urandom()}};
        end
        if (jobq1.size() > 0) begin
            i_req_valid[1]   = wd_en ? ($urandom_range(0, 5) != 0) : 1'b1;
            i_req_a[511:256] = jobq1[0].a;
            i_req_d[511:256] = jobq1[0].d;
            i_req_n[511:256] = jobq1[0].n;
        end else begin
            i_req_valid[1]   = 1'b0;
            i_req_a[511:256] = {8{$urandom()}};
            i_req_d[511:256] = {8{$urandom()}};
            i_req_n[511:256] = {8{$urandom()}};
        end
        case (rsp_mode)
            0:       i_rsp_ready = 2'($urandom_range(0, 3));
            1:       i_rsp_ready = 2'b11;
            default: i_rsp_ready = 2'b00;
        endcase
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_req_valid = 2'b00;
        i_rsp_ready = 2'b00;
        jobq0.delete();
        jobq1.delete();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int  i;
        logic done;
        i = 0;
        done = 1'b0;
        while (i < budget && !done) begin
            tick();
            i++;
            done = (jobq0.size() == 0) && (jobq1.size() == 0) && !m_busy && (i_req_valid == 2'b00);
        end
        check_val(tag, done, 256'd1);
    endtask

    int   base;
    int   w;
    logic [255:0] d0;

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        i_rst = 1'b0; i_req_valid = 2'b00; i_rsp_ready = 2'b00;
        i_req_a = 512'd0; i_req_d = 512'd0; i_req_n = 512'd0;
        core_hang = 1'b0; rsp_mode = 1; wd_en = 1'b0;
        do_reset();

        // 1: single job from requester 0
        base = rsp_log.size();
        jobq0.push_back(mk(5, 3, 33));
        run_until_done("t1_drain", 100);
        check_val("t1_count", 256'(rsp_log.size() - base), 256'd1);
        if (rsp_log.size() > base) begin
            check_val("t1_owner", rsp_log[base].owner, 256'd0);
            check_val("t1_data", rsp_log[base].data, 256'd26);
            check_val("t1_err", rsp_log[base].err, 256'd0);
        end

        // 2: simultaneous requests right after reset
        do_reset();
        base = rsp_log.size();
        jobq0.push_back(mk(5, 3, 33));
        jobq1.push_back(mk(7, 2, 15));
        run_until_done("t2_drain", 200);
        check_val("t2_count", 256'(rsp_log.size() - base), 256'd2);
        if (rsp_log.size() > base + 1) begin
            check_val("t2_first_owner", rsp_log[base].owner, 256'd0);
            check_val("t2_first_data", rsp_log[base].data, 256'd26);
            check_val("t2_second_owner", rsp_log[base+1].owner, 256'd1);
            check_val("t2_second_data", rsp_log[base+1].data, 256'd4);
        end

        // 3: back-to-back jobs from requester 1
        base = rsp_log.size();
        jobq1.push_back(mk(7, 2, 15));
        jobq1.push_back(mk(3, 4, 10));
        run_until_done("t3_drain", 200);
        check_val("t3_count", 256'(rsp_log.size() - base), 256'd2);
        if (rsp_log.size() > base + 1) begin
            check_val("t3_data0", rsp_log[base].data, 256'd4);
            check_val("t3_data1", rsp_log[base+1].data, 256'd1);
            check_val("t3_owner1", rsp_log[base+1].owner, 256'd1);
        end

        // 4: response back-pressure with a pending request from requester 1
        rsp_mode = 2;
        jobq0.push_back(mk(5, 3, 33));
        w = 0;
        while (w < 100 && !o_rsp_valid[0]) begin tick(); w++; end
        check_val("t4_rsp_seen", o_rsp_valid[0], 256'd1);
        jobq1.push_back(mk(3, 4, 10));
        d0 = o_rsp_data;
        check_val("t4_data", d0, 256'd26);
        repeat (10) begin
            tick();
            check_val("t4_hold_valid", o_rsp_valid, 256'd1);
            check_val("t4_hold_data", o_rsp_data, d0);
            check_val("t4_hold_ready", o_req_ready, 256'd0);
        end
        rsp_mode = 1;
        tick();
        tick();
        check_val("t4_grant_after", o_req_ready, 256'd2);
        run_until_done("t4_drain", 200);

        // 5: reset in the middle of BUSY
        core_hang = 1'b1;
        jobq0.push_back(mk(9, 5, 77));
        w = 0;
        while (w < 20 && !o_core_start) begin tick(); w++; end
        check_val("t5_started", o_core_start, 256'd1);
        repeat (5) tick();
        base = rsp_log.size();
        #2 i_rst = 1'b0;
        #1;
        check_val("t5_rsp_valid", o_rsp_valid, 256'd0);
        check_val("t5_rsp_data", o_rsp_data, 256'd0);
        check_val("t5_core_rst_n", o_core_rst_n, 256'd0);
        check_val("t5_core_start", o_core_start, 256'd0);
        check_val("t5_core_a", o_core_a, 256'd0);
        jobq0.delete();
        i_req_valid = 2'b00;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        core_hang = 1'b0;
        check_val("t5_no_rsp", 256'(rsp_log.size() - base), 256'd0);
        jobq0.push_back(mk(7, 2, 15));
        run_until_done("t5_drain", 100);
        check_val("t5_new_count", 256'(rsp_log.size() - base), 256'd1);
        if (rsp_log.size() > base) check_val("t5_new_data", rsp_log[base].data, 256'd4);

`ifdef RSA_ARB_TIMEOUT_EN
        // 6: watchdog expiry
        core_hang = 1'b1;
        base = rsp_log.size();
        jobq0.push_back(mk(5, 3, 33));
        run_until_done("t6_drain", 300);
        check_val("t6_latency", 256'(rspv_cyc - start_cyc), 256'd101);
        check_val("t6_count", 256'(rsp_log.size() - base), 256'd1);
        if (rsp_log.size() > base) begin
            check_val("t6_err", rsp_log[base].err, 256'd1);
            check_val("t6_data", rsp_log[base].data, 256'd0);
        end
        core_hang = 1'b0;
        jobq1.push_back(mk(3, 4, 10));
        run_until_done("t6_recover", 100);
`endif

        // randomized traffic with withdrawal and random response back-pressure
        rsp_mode = 0;
        wd_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 20; j++) begin
                if ($urandom_range(0, 1) == 0)
                    jobq0.push_back(mk(int'($urandom_range(0, 999)), int'($urandom_range(1, 20)),
                                       int'($urandom_range(2, 999))));
                else
                    jobq1.push_back(mk(int'($urandom_range(0, 999)), int'($urandom_range(1, 20)),
                                       int'($urandom_range(2, 999))));
            end
            run_until_done("rand_drain", 5000);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rsa_job_arbiter.md
# rsa_job_arbiter

Shares one RSA256 exponentiation core between two requesters. Accepts jobs (a, d, n) on per-requester valid/ready ports and grants round-robin. For each job it clears the core with a one-cycle reset pulse, launches it with a one-cycle start, waits for completion, and returns the 256-bit result to the owning requester on a valid/ready response port. Sits between the host/bus front-end and the core, and owns every core control signal.

## Interface
Parameters:
- TIMEOUT_CYCLES, 200000: watchdog limit in cycles from core start. Used only when RSA_ARB_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-low.
- i_req_valid  in  2  job request, bit k is requester k.
- o_req_ready  out  2  job accept, bit k; combinational.
- i_req_a  in  512  ciphertext; requester k at bits [256k+255:256k].
- i_req_d  in  512  exponent, same packing.
- i_req_n  in  512  modulus, same packing.
- o_rsp_valid  out  2  result valid for requester k; registered.
- i_rsp_ready  in  2  result accept, bit k.
- o_rsp_data  out  256  result, shared by both requesters.
- o_rsp_err  out  1  timeout flag, qualified by o_rsp_valid.
- o_core_rst_n  out  1  core reset; registered, active-low.
- o_core_start  out  1  core start pulse; registered.
- o_core_a, o_core_d, o_core_n  out  256 each  latched job operands; registered.
- i_core_result  in  256  core result.
- i_core_finished  in  1  core done. This is a level that stays high until the core is reset.

## Operation
States: IDLE, CLR, START, BUSY, RESP. A transaction occurs when valid and ready are both high on a clock edge.

- **IDLE**
  - If exactly one i_req_valid bit is high, that requester is selected.
  - If both are high, the requester that is not last_grant is selected.
  - o_req_ready is high only on the selected bit, and only in IDLE.
  - On the handshake, latch a/d/n into o_core_a/d/n, set owner=k, go to CLR.
- **CLR**
  - o_core_rst_n is low for exactly this cycle. This clears the core's sticky finished flag and its internal state.
  - Go to START.
- **START**
  - o_core_start is high for exactly this cycle.
  - Clear the watchdog counter. Go to BUSY.
- **BUSY**
  - When i_core_finished is high, latch i_core_result into o_rsp_data, set o_rsp_err=0, go to RESP.
  - Ignore i_core_finished in every other state.
- **RESP**
  - o_rsp_valid[owner] is high. o_rsp_data and o_rsp_err are held stable.
  - On i_rsp_ready[owner], set last_grant=owner and go to IDLE.
  - i_rsp_ready on the non-owner bit is ignored.
  - No new request is accepted until this state exits.
- **Operand stability**: o_core_a/d/n hold their values from acceptance until the next acceptance, because the core reads them for the whole job.
- **Request withdrawal**: a requester may drop valid before its handshake without side effects. After acceptance, its inputs are don't-care.
- **Reset values**
  - State IDLE, last_grant=1 (so requester 0 wins the first tie).
  - o_core_rst_n=0, so the core is held in reset during arbiter reset.
  - o_core_start=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_core_a/d/n=0.
  - o_core_rst_n returns to 1 on the first clock edge after i_rst releases.
- **Reset mid-job**: asserting i_rst in any state returns everything to the reset values immediately. The pending job is lost and no response is issued.

## Timing
- Handshake at edge T:
  - CLR during cycle T+1 (o_core_rst_n low).
  - START during T+2 (o_core_start high).
  - BUSY from T+3.
- i_core_finished sampled high at edge F: o_rsp_valid is high from F+1.
- Minimum time from request acceptance to o_rsp_valid: core latency + 4 cycles.
- Response accepted at edge R: state is IDLE in cycle R+1, and a new grant is possible at edge R+1.
- Back-to-back jobs: at least 1 idle cycle between jobs.
- A response accepted in the same cycle it becomes valid occupies exactly one RESP cycle.

## Configuration
RSA_ARB_TIMEOUT_EN:
- **Defined**
  - A 32-bit counter increments every BUSY cycle.
  - If it reaches TIMEOUT_CYCLES before i_core_finished, go to RESP with o_rsp_err=1 and o_rsp_data=0.
  - The core is left running and is cleared by the next job's CLR.
- **Undefined**
  - BUSY waits indefinitely. o_rsp_err is tied 0. TIMEOUT_CYCLES is unused and no counter is synthesized.

## Test plan
1. Requester 0 sends a=5, d=3, n=33:
   - o_core_rst_n is low one cycle, then o_core_start is high one cycle.
   - o_rsp_valid=2'b01, o_rsp_data=26, o_rsp_err=0; o_rsp_valid[1] stays 0.
2. After reset, both requesters assert valid in the same cycle (req0: 5,3,33; req1: 7,2,15):
   - Requester 0 is granted first and receives 26.
   - Requester 1 is then granted and receives 4.
3. Requester 1 sends two jobs back-to-back (7,2,15 then 3,4,10) while requester 0 is idle:
   - Results are 4 and 1.
   - Each o_core_start is preceded by exactly one cycle of o_core_rst_n low.
4. Hold i_rsp_ready low for 10 cycles in RESP while i_req_valid[1]=1:
   - o_rsp_valid and o_rsp_data are stable, o_req_ready=0.
   - Requester 1 is granted one cycle after the response handshake.
5. Assert i_rst low mid-BUSY:
   - All outputs take reset values immediately and o_core_rst_n=0.
   - No response is issued; a new job after reset completes correctly.
6. With RSA_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, and i_core_finished held 0:
   - RESP is entered 100 BUSY cycles after the start pulse, with o_rsp_err=1 and o_rsp_data=0.
